// File: rtl/pcs_block_lock_ctrl.sv
// -----------------------------------------------------------------------------
// pcs_block_lock_ctrl
// 64b/66b block-lock state machine. It hunts for sync-header alignment,
// requests one-bit gearbox slips, and keeps lock while the per-window invalid
// header count stays below its limit. An optional high-BER monitor runs while
// locked.
//
// Optional feature macro: PCS_HI_BER_MON_EN (compiles in the high-BER monitor).
//
// Ports
//   clk            in   single clock, rising edge
//   rst            in   synchronous active-high reset
//   rx_sh[1:0]     in   sync header of the current 66b block
//   rx_sh_valid    in   rx_sh qualifier
//   rx_bitslip     out  one-cycle gearbox slip request
//   rx_block_lock  out  block alignment acquired
//   rx_high_ber    out  high bit-error-rate indication (0 without the monitor)
//   rx_status      out  rx_block_lock & ~rx_high_ber
// -----------------------------------------------------------------------------
module pcs_block_lock_ctrl #(
    parameter int unsigned SH_CNT_MAX     = 64,
    parameter int unsigned SH_INVALID_MAX = 16,
    parameter int unsigned SLIP_WAIT      = 7,
    parameter int unsigned BER_WINDOW     = 20141,
    parameter int unsigned BER_THRESH     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] rx_sh,
    input  logic       rx_sh_valid,
    output logic       rx_bitslip,
    output logic       rx_block_lock,
    output logic       rx_high_ber,
    output logic       rx_status
);

    localparam int unsigned SH_W   = $clog2(SH_CNT_MAX + 1);
    localparam int unsigned INV_W  = $clog2(SH_INVALID_MAX + 1);
    localparam int unsigned WAIT_W = $clog2(SLIP_WAIT + 1);

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_HUNT   = 3'd1,
        ST_SLIP   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_LOCKED = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [SH_W-1:0]     sh_cnt_q, sh_cnt_d;
    logic [INV_W-1:0]    inv_cnt_q, inv_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;

    logic sh_ok;
    logic sh_bad;
    logic lock_d;
    logic ber_hi_d;

    // Header classification, qualified by rx_sh_valid
    assign sh_ok  = rx_sh_valid && ((rx_sh == 2'b01) || (rx_sh == 2'b10));
    assign sh_bad = rx_sh_valid && ((rx_sh == 2'b00) || (rx_sh == 2'b11));

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            sh_cnt_q   <= '0;
            inv_cnt_q  <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sh_cnt_q   <= sh_cnt_d;
            inv_cnt_q  <= inv_cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d    = state_q;
        sh_cnt_d   = sh_cnt_q;
        inv_cnt_d  = inv_cnt_q;
        wait_cnt_d = wait_cnt_q;

        unique case (state_q)
            ST_INIT: begin
                state_d    = ST_HUNT;
                sh_cnt_d   = '0;
                inv_cnt_d  = '0;
                wait_cnt_d = '0;
            end

            ST_HUNT: begin
                if (sh_bad) begin
                    state_d = ST_SLIP;
                end else if (sh_ok) begin
                    if (sh_cnt_q == SH_W'(SH_CNT_MAX - 1)) begin
                        // Counters restart so the first locked window is a full one
                        state_d   = ST_LOCKED;
                        sh_cnt_d  = '0;
                        inv_cnt_d = '0;
                    end else begin
                        sh_cnt_d = sh_cnt_q + SH_W'(1);
                    end
                end
            end

            ST_SLIP: begin
                state_d    = ST_WAIT;
                sh_cnt_d   = '0;
                inv_cnt_d  = '0;
                wait_cnt_d = '0;
            end

            ST_WAIT: begin
                // Headers ignored while the gearbox settles
                if (wait_cnt_q == WAIT_W'(SLIP_WAIT - 1)) begin
                    state_d    = ST_HUNT;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end

            ST_LOCKED: begin
                if (sh_ok || sh_bad) begin
                    // Lock loss wins over a window restart on the same header
                    if (sh_bad && (inv_cnt_q == INV_W'(SH_INVALID_MAX - 1))) begin
                        state_d   = ST_SLIP;
                        sh_cnt_d  = '0;
                        inv_cnt_d = '0;
                    end else if (sh_cnt_q == SH_W'(SH_CNT_MAX - 1)) begin
                        sh_cnt_d  = '0;
                        inv_cnt_d = '0;
                    end else begin
                        sh_cnt_d = sh_cnt_q + SH_W'(1);
                        if (sh_bad) begin
                            inv_cnt_d = inv_cnt_q + INV_W'(1);
                        end
                    end
                end
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign lock_d = (state_d == ST_LOCKED);

`ifdef PCS_HI_BER_MON_EN
    localparam int unsigned BT_W = $clog2(BER_WINDOW + 1);
    localparam int unsigned BC_W = $clog2(BER_THRESH + 1);

    logic [BT_W-1:0] ber_tmr_q, ber_tmr_d;
    logic [BC_W-1:0] ber_cnt_q, ber_cnt_d;

    // High-BER window timer and saturating invalid-header counter
    always_ff @(posedge clk) begin
        if (rst) begin
            ber_tmr_q <= '0;
            ber_cnt_q <= '0;
        end else begin
            ber_tmr_q <= ber_tmr_d;
            ber_cnt_q <= ber_cnt_d;
        end
    end

    // Monitor next-state; runs only while lock is already reported
    always_comb begin
        ber_tmr_d = ber_tmr_q;
        ber_cnt_d = ber_cnt_q;
        ber_hi_d  = rx_high_ber;

        if (!lock_d) begin
            ber_tmr_d = '0;
            ber_cnt_d = '0;
            ber_hi_d  = 1'b0;
        end else if (rx_block_lock) begin
            if (ber_tmr_q == BT_W'(BER_WINDOW - 1)) begin
                // Window ends: keep the flag only if this window hit threshold;
                // an invalid header on this cycle belongs to the new window
                ber_tmr_d = '0;
                ber_hi_d  = (ber_cnt_q == BC_W'(BER_THRESH));
                ber_cnt_d = sh_bad ? BC_W'(1) : '0;
            end else begin
                ber_tmr_d = ber_tmr_q + BT_W'(1);
                if (sh_bad && (ber_cnt_q != BC_W'(BER_THRESH))) begin
                    ber_cnt_d = ber_cnt_q + BC_W'(1);
                end
            end
            if (sh_bad && (ber_cnt_d == BC_W'(BER_THRESH))) begin
                ber_hi_d = 1'b1;
            end
        end
    end
`else
    logic unused_ber_cfg;

    assign ber_hi_d       = 1'b0;
    assign unused_ber_cfg = ^{BER_WINDOW, BER_THRESH};
`endif

    // Outputs registered from next-state values
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_bitslip    <= 1'b0;
            rx_block_lock <= 1'b0;
            rx_high_ber   <= 1'b0;
            rx_status     <= 1'b0;
        end else begin
            rx_bitslip    <= (state_d == ST_SLIP);
            rx_block_lock <= lock_d;
            rx_high_ber   <= ber_hi_d;
            rx_status     <= lock_d && !ber_hi_d;
        end
    end

endmodule
